// File: rtl/alu_seq_unit.sv
// rtl/alu_seq_unit.sv - registered ALU with aluop/funct decode and iterative shifts
// Optional feature macro: ALU_SEQ_SRL_EN (adds funct 000110 -> logical shift right, gout 111)
module alu_seq_unit #(
  parameter int WIDTH   = 16,
  parameter int SHAMT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       aluop,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic [2:0]       gout
);

  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b110;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_NAND = 3'b100;
  localparam logic [2:0] OP_SLL  = 3'b101;
`ifdef ALU_SEQ_SRL_EN
  localparam logic [2:0] OP_SRL  = 3'b111;
`endif

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_EXEC  = 2'd1,
    ST_SHIFT = 2'd2
  } state_t;

  state_t             state_q;
  logic [WIDTH-1:0]   opa_q;    // operand A; doubles as the shift accumulator
  logic [WIDTH-1:0]   opb_q;
  logic [SHAMT_W-1:0] cnt_q;
  logic [WIDTH-1:0]   result_q;
  logic               zero_q;
  logic               done_q;
  logic               busy_q;
  logic [2:0]         gout_q;

  logic [2:0]         gout_d;
  logic [WIDTH-1:0]   opb_d;
  logic               shift_d;
  logic [WIDTH-1:0]   exec_res;

  // Decode aluop/funct into the control code; aluop takes priority over funct
  always_comb begin
    gout_d  = OP_ADD;
    opb_d   = b;
    shift_d = 1'b0;
    if (aluop == 2'b00) begin
      gout_d = OP_ADD;
    end else if (aluop[0]) begin
      gout_d = OP_SUB;
    end else begin
      case (funct)
        6'b000001: begin
          gout_d  = OP_SLL;
          shift_d = 1'b1;
        end
        6'b000010: opb_d  = '0;       // move is an add with B forced to zero
        6'b000011: gout_d = OP_NAND;
        6'b000100: gout_d = OP_OR;
`ifdef ALU_SEQ_SRL_EN
        6'b000110: begin
          gout_d  = OP_SRL;
          shift_d = 1'b1;
        end
`endif
        default:   gout_d = OP_ADD;
      endcase
    end
  end

  // Single-cycle datapath working on the latched operands
  always_comb begin
    exec_res = opa_q + opb_q;
    case (gout_q)
      OP_SUB:  exec_res = opa_q - opb_q;
      OP_NAND: exec_res = ~(opa_q & opb_q);
      OP_OR:   exec_res = opa_q | opb_q;
      default: exec_res = opa_q + opb_q;
    endcase
  end

  // Control FSM with registered outputs; start is only honoured in IDLE
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      opa_q    <= '0;
      opb_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      gout_q   <= OP_ADD;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            opa_q   <= a;
            opb_q   <= opb_d;
            gout_q  <= gout_d;
            cnt_q   <= b[SHAMT_W-1:0];
            busy_q  <= 1'b1;
            state_q <= shift_d ? ST_SHIFT : ST_EXEC;
          end
        end
        ST_EXEC: begin
          result_q <= exec_res;
          zero_q   <= (exec_res == '0);
          done_q   <= 1'b1;
          busy_q   <= 1'b0;
          state_q  <= ST_IDLE;
        end
        ST_SHIFT: begin
          if (cnt_q == '0) begin
            result_q <= opa_q;
            zero_q   <= (opa_q == '0);
            done_q   <= 1'b1;
            busy_q   <= 1'b0;
            state_q  <= ST_IDLE;
          end else begin
`ifdef ALU_SEQ_SRL_EN
            if (gout_q == OP_SRL) opa_q <= opa_q >> 1;
            else                  opa_q <= opa_q << 1;
`else
            opa_q <= opa_q << 1;
`endif
            cnt_q <= cnt_q - SHAMT_W'(1);
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign zero   = zero_q;
  assign gout   = gout_q;

endmodule
